// File: rtl/serial_adder_harness.sv
// Serial-load / serial-drain timing harness around a selectable 64-bit adder core.
// Optional subtraction mode (a + ~b + 1) is enabled by defining ADDER_HARNESS_SUB_EN.
module serial_adder_harness #(
    parameter int unsigned ADDER_TYPE      = 4,
    parameter int unsigned WIDTH           = 64,
    parameter int unsigned LANES           = 1,
    parameter int unsigned CSA_BLOCK_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic             cin_in,
`ifdef ADDER_HARNESS_SUB_EN
    input  logic             sub_in,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] a_in,
    input  logic [LANES-1:0] b_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             done_out,
    output logic             busy_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANES-1:0] sum_ser,
    output logic             out_last
);

    localparam int unsigned BEATS = WIDTH / LANES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (ADDER_TYPE > 5) begin : g_bad_type
        $error("serial_adder_harness: ADDER_TYPE must be 0..5");
    end
    if (ADDER_TYPE < 5 && WIDTH != 64) begin : g_bad_width
        $error("serial_adder_harness: structural adder cores require WIDTH=64");
    end
    if (WIDTH % LANES != 0) begin : g_bad_lanes
        $error("serial_adder_harness: WIDTH must be a multiple of LANES");
    end
    if (ADDER_TYPE == 1 && WIDTH % CSA_BLOCK_WIDTH != 0) begin : g_bad_csa
        $error("serial_adder_harness: WIDTH must be a multiple of CSA_BLOCK_WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StLoad, StCompute, StDrain} state_e;

    state_e             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_cin;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_core_sum;
    logic               r_core_cout;
    logic               r_pending;
    logic [WIDTH-1:0]   r_sum_out;
    logic               r_cout_out;
    logic               r_done;
    logic               r_out_valid;
    logic               r_out_last;

    logic [WIDTH-1:0]       w_core_sum;
    logic                   w_core_cout;
    logic [LANES-1:0]       w_b_lane;
    logic                   w_cin_eff;
    logic [WIDTH+LANES-1:0] w_a_cat;
    logic [WIDTH+LANES-1:0] w_b_cat;
    logic [CNT_W-1:0]       w_cnt_inc;

`ifdef ADDER_HARNESS_SUB_EN
    logic r_sub;
    // B is inverted as it is shifted in, so the core always sees a plain addition.
    assign w_b_lane  = b_in ^ {LANES{r_sub}};
    assign w_cin_eff = sub_in | cin_in;
`else
    assign w_b_lane  = b_in;
    assign w_cin_eff = cin_in;
`endif

    assign w_a_cat   = {a_in, r_a};
    assign w_b_cat   = {w_b_lane, r_b};
    assign w_cnt_inc = r_cnt + 1'b1;

    // Adder cores: purely combinational between the operand and result registers.
    if (ADDER_TYPE == 0) begin : g_rca
        logic w_c;
        always_comb begin
            w_core_sum = '0;
            w_c        = r_cin;
            for (int i = 0; i < WIDTH; i++) begin
                w_core_sum[i] = r_a[i] ^ r_b[i] ^ w_c;
                w_c           = (r_a[i] & r_b[i]) | (w_c & (r_a[i] ^ r_b[i]));
            end
            w_core_cout = w_c;
        end
    end else if (ADDER_TYPE == 1) begin : g_csel
        localparam int unsigned BW = CSA_BLOCK_WIDTH;
        logic        w_c;
        logic [BW:0] w_s0;
        logic [BW:0] w_s1;
        always_comb begin
            w_core_sum = '0;
            w_c        = r_cin;
            w_s0       = '0;
            w_s1       = '0;
            for (int k = 0; k < int'(WIDTH / BW); k++) begin
                w_s0 = {1'b0, r_a[k*BW +: BW]} + {1'b0, r_b[k*BW +: BW]};
                w_s1 = {1'b0, r_a[k*BW +: BW]} + {1'b0, r_b[k*BW +: BW]} + (BW+1)'(1);
                w_core_sum[k*BW +: BW] = w_c ? w_s1[BW-1:0] : w_s0[BW-1:0];
                w_c                    = w_c ? w_s1[BW] : w_s0[BW];
            end
            w_core_cout = w_c;
        end
    end else if (ADDER_TYPE == 2) begin : g_ling
        // Ling pseudo-carry: h[i+1] = g[i] | t[i-1]&h[i]; real carry c[i] = t[i-1]&h[i].
        logic w_h;
        logic w_tp;
        logic w_ci;
        always_comb begin
            w_core_sum = '0;
            w_h        = r_cin;
            w_tp       = 1'b1;
            w_ci       = 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                w_ci          = w_tp & w_h;
                w_core_sum[i] = r_a[i] ^ r_b[i] ^ w_ci;
                w_h           = (r_a[i] & r_b[i]) | (w_tp & w_h);
                w_tp          = r_a[i] | r_b[i];
            end
            w_core_cout = w_tp & w_h;
        end
    end else if (ADDER_TYPE == 3) begin : g_cla
        // Kogge-Stone prefix with carry-in folded into bit 0.
        logic [WIDTH-1:0] w_p;
        logic [WIDTH-1:0] w_g;
        logic [WIDTH-1:0] w_pp;
        logic [WIDTH-1:0] w_gn;
        logic [WIDTH-1:0] w_pn;
        always_comb begin
            w_p    = r_a ^ r_b;
            w_g    = r_a & r_b;
            w_pp   = w_p;
            w_g[0] = w_g[0] | (w_p[0] & r_cin);
            w_gn   = '0;
            w_pn   = '0;
            for (int d = 1; d < WIDTH; d = d * 2) begin
                w_gn = w_g;
                w_pn = w_pp;
                for (int i = d; i < WIDTH; i++) begin
                    w_gn[i] = w_g[i] | (w_pp[i] & w_g[i-d]);
                    w_pn[i] = w_pp[i] & w_pp[i-d];
                end
                w_g  = w_gn;
                w_pp = w_pn;
            end
            w_core_sum  = w_p ^ {w_g[WIDTH-2:0], r_cin};
            w_core_cout = w_g[WIDTH-1];
        end
    end else if (ADDER_TYPE == 4) begin : g_cskip
        localparam int unsigned SW = 4;
        logic w_c;
        logic w_cb;
        logic w_pall;
        always_comb begin
            w_core_sum = '0;
            w_c        = r_cin;
            w_cb       = 1'b0;
            w_pall     = 1'b0;
            for (int k = 0; k < int'(WIDTH / SW); k++) begin
                w_cb   = w_c;
                w_pall = 1'b1;
                for (int j = 0; j < int'(SW); j++) begin
                    w_core_sum[k*SW+j] = r_a[k*SW+j] ^ r_b[k*SW+j] ^ w_cb;
                    w_cb   = (r_a[k*SW+j] & r_b[k*SW+j]) | ((r_a[k*SW+j] ^ r_b[k*SW+j]) & w_cb);
                    w_pall = w_pall & (r_a[k*SW+j] ^ r_b[k*SW+j]);
                end
                w_c = w_pall ? w_c : w_cb;
            end
            w_core_cout = w_c;
        end
    end else begin : g_behav
        assign {w_core_cout, w_core_sum} = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_cnt       <= '0;
            r_core_sum  <= '0;
            r_core_cout <= 1'b0;
            r_pending   <= 1'b0;
            r_sum_out   <= '0;
            r_cout_out  <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
`ifdef ADDER_HARNESS_SUB_EN
            r_sub       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (start_in && r_state != StCompute) begin
                r_state     <= StLoad;
                r_a         <= '0;
                r_b         <= '0;
                r_cnt       <= '0;
                r_cin       <= w_cin_eff;
                r_pending   <= 1'b0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
`ifdef ADDER_HARNESS_SUB_EN
                r_sub       <= sub_in;
`endif
            end else begin
                unique case (r_state)
                    StIdle: begin
                    end
                    StLoad: begin
                        if (in_valid) begin
                            r_a <= w_a_cat[WIDTH+LANES-1:LANES];
                            r_b <= w_b_cat[WIDTH+LANES-1:LANES];
                            if (r_cnt == CNT_W'(BEATS - 1)) begin
                                r_cnt   <= '0;
                                r_state <= StCompute;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end
                    end
                    StCompute: begin
                        r_core_sum  <= w_core_sum;
                        r_core_cout <= w_core_cout;
                        r_pending   <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= StDrain;
                    end
                    StDrain: begin
                        if (r_pending) begin
                            r_pending   <= 1'b0;
                            r_sum_out   <= r_core_sum;
                            r_cout_out  <= r_core_cout;
                            r_done      <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_out_last  <= (BEATS == 1);
                        end else if (r_out_valid && out_ready) begin
                            if (r_out_last) begin
                                r_out_valid <= 1'b0;
                                r_out_last  <= 1'b0;
                                r_state     <= StIdle;
                            end else begin
                                r_cnt      <= w_cnt_inc;
                                r_out_last <= (w_cnt_inc == CNT_W'(BEATS - 1));
                            end
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign in_ready  = (r_state == StLoad);
    assign busy_out  = (r_state != StIdle);
    assign sum_out   = r_sum_out;
    assign cout_out  = r_cout_out;
    assign done_out  = r_done;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign sum_ser   = r_out_valid ? r_sum_out[r_cnt*LANES +: LANES] : '0;

endmodule

// File: tb/tb_serial_adder_harness.sv
// Directed self-checking bench for serial_adder_harness (WIDTH=64, LANES=1).
module tb_serial_adder_harness;

    parameter int unsigned ADDER_TYPE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_in = 1'b0;
    logic        cin_in = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [0:0]  a_in = '0;
    logic [0:0]  b_in = '0;
    logic [63:0] sum_out;
    logic        cout_out;
    logic        done_out;
    logic        busy_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [0:0]  sum_ser;
    logic        out_last;
`ifdef ADDER_HARNESS_SUB_EN
    logic        sub_in = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    serial_adder_harness #(
        .ADDER_TYPE     (ADDER_TYPE),
        .WIDTH          (64),
        .LANES          (1),
        .CSA_BLOCK_WIDTH(16)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_in (start_in),
        .cin_in   (cin_in),
`ifdef ADDER_HARNESS_SUB_EN
        .sub_in   (sub_in),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .sum_out  (sum_out),
        .cout_out (cout_out),
        .done_out (done_out),
        .busy_out (busy_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum_ser  (sum_ser),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done_out === 1'b1) done_cnt++;

    // Starts a transaction and shifts in all 64 beats; ends on the negedge after the last accept.
    task automatic load_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                           input bit stall);
        start_in = 1'b1;
        cin_in   = cin;
        @(negedge clk);
        start_in = 1'b0;
        cin_in   = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (stall && (k % 3 == 1)) begin
                in_valid = 1'b0;
                a_in     = ~a[k];
                b_in     = ~b[k];
                @(negedge clk);
            end
            in_valid = 1'b1;
            a_in     = a[k];
            b_in     = b[k];
            @(negedge clk);
        end
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done_out !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Collects serial beats; out_ready held low for 10 cycles when beat hold_at is pending.
    task automatic drain(input int hold_at, output logic [63:0] s, output int beats,
                         output int last_err);
        int cyc;
        int hold;
        s = '0; beats = 0; last_err = 0; cyc = 0; hold = 0;
        while (beats < 64 && cyc < 300) begin
            if (beats == hold_at && hold < 10) begin
                out_ready = 1'b0;
                hold++;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid === 1'b1 && out_ready) begin
                s[beats] = sum_ser[0];
                if (out_last !== (beats == 63)) last_err++;
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
    endtask

    // Full transaction with latency, result, stream and return-to-idle checks.
    task automatic run_txn(input string name, input logic [63:0] a, input logic [63:0] b,
                           input logic cin, input bit stall, input int hold_at,
                           input logic [63:0] exp_sum, input logic exp_cout);
        int lat, beats, last_err, d0;
        logic [63:0] s;
        d0 = done_cnt;
        load_op(a, b, cin, stall);
        checks++;
        if (in_ready !== 1'b0 || busy_out !== 1'b1) begin
            failures++;
            $display("FAIL %s_compute_flags: in_ready=%b busy=%b required 0/1", name, in_ready,
                     busy_out);
        end
        wait_done(lat);
        checks++;
        if (lat != 2) begin
            failures++;
            $display("FAIL %s_latency: got %0d required 2", name, lat);
        end
        checks++;
        if (sum_out !== exp_sum || cout_out !== exp_cout) begin
            failures++;
            $display("FAIL %s_sum: got %h/%b required %h/%b", name, sum_out, cout_out, exp_sum,
                     exp_cout);
        end
        drain(hold_at, s, beats, last_err);
        checks++;
        if (s !== exp_sum || beats != 64 || last_err != 0) begin
            failures++;
            $display("FAIL %s_stream: got %h beats=%0d last_err=%0d required %h beats=64",
                     name, s, beats, last_err, exp_sum);
        end
        checks++;
        if (out_valid !== 1'b0 || busy_out !== 1'b0 || done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL %s_idle: out_valid=%b busy=%b done_pulses=%0d required 0/0/1", name,
                     out_valid, busy_out, done_cnt - d0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({done_out, busy_out, out_valid, in_ready, out_last, cout_out, sum_ser} !== 7'b0 ||
            sum_out !== 64'h0) begin
            failures++;
            $display("FAIL reset_outputs: got flags=%b sum=%h required 0",
                     {done_out, busy_out, out_valid, in_ready, out_last, cout_out, sum_ser},
                     sum_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_out !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b in_ready=%b required 0/0", busy_out, in_ready);
        end
    endtask

    task automatic test_carry_chain();
        run_txn("carry_chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 99, 64'h0, 1'b1);
    endtask

    task automatic test_serial_stream();
        run_txn("serial_stream", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0,
                99, 64'h0, 1'b1);
    endtask

    task automatic test_backpressure();
        run_txn("backpressure", 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0003, 1'b0, 1'b1,
                30, 64'h4, 1'b1);
    endtask

    task automatic test_abort_load();
        int d0;
        d0 = done_cnt;
        start_in = 1'b1;
        cin_in   = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            a_in     = 1'b1;
            b_in     = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (sum_out !== 64'h4 || cout_out !== 1'b1 || done_cnt != d0) begin
            failures++;
            $display("FAIL abort_hold: got %h/%b pulses=%0d required 4/1/0", sum_out, cout_out,
                     done_cnt - d0);
        end
        run_txn("abort_load", 64'h5, 64'h7, 1'b0, 1'b0, 99, 64'hC, 1'b0);
    endtask

    task automatic test_start_in_compute();
        int lat;
        load_op(64'h1234_5678_0000_0000, 64'h0000_0000_8765_4321, 1'b1, 1'b0);
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        lat = 1;
        while (done_out !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 2 || sum_out !== 64'h1234_5678_8765_4322 || cout_out !== 1'b0) begin
            failures++;
            $display("FAIL start_in_compute: lat=%0d sum=%h/%b required 2 12345678_87654322/0",
                     lat, sum_out, cout_out);
        end
        // Abort during drain: stream stops, result holds until the new transaction completes.
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        run_txn("abort_drain", 64'h00FF, 64'h0F01, 1'b0, 1'b0, 99, 64'h1000, 1'b0);
    endtask

    task automatic test_reset_in_drain();
        int lat;
        load_op(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 1'b0);
        wait_done(lat);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({done_out, busy_out, out_valid, in_ready, out_last, cout_out, sum_ser} !== 7'b0 ||
            sum_out !== 64'h0) begin
            failures++;
            $display("FAIL reset_in_drain: got flags=%b sum=%h required 0",
                     {done_out, busy_out, out_valid, in_ready, out_last, cout_out, sum_ser},
                     sum_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn("after_reset", 64'h2, 64'h3, 1'b1, 1'b0, 99, 64'h6, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_first", 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 99,
                64'h0000_0000_0000_0000, 1'b1);
        run_txn("b2b_second", 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 99,
                64'h8000_0000_0000_0000, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (sum_out !== 64'h8000_0000_0000_0000 || sum_ser !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_hold: sum=%h ser=%b valid=%b required 80000000_00000000/0/0",
                     sum_out, sum_ser, out_valid);
        end
    endtask

`ifdef ADDER_HARNESS_SUB_EN
    task automatic test_sub();
        sub_in = 1'b1;
        run_txn("sub", 64'h3, 64'h5, 1'b0, 1'b0, 99, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        sub_in = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_carry_chain();
        test_serial_stream();
        test_backpressure();
        test_abort_load();
        test_start_in_compute();
        test_reset_in_drain();
        test_back_to_back();
`ifdef ADDER_HARNESS_SUB_EN
        test_sub();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
